// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: fetch FSM states, reset address, NOP encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // Word-address increment; 30-bit and wraps.
  function automatic logic [29:0] word_inc(input logic [29:0] w);
    return w + 30'd1;
  endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch performance counters: handoffs into ID and bubbles inserted into ID.
// Only instantiated when IF_PERF_CNT_EN is defined. Both counters wrap.
module if_perf_cnt (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc_fetch,
  input  logic        inc_bubble,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);

  logic [1:0]       inc;
  logic [1:0][31:0] cnt_all;

  assign inc = {inc_bubble, inc_fetch};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_reg;

      // Free-running event counter, wraps at 2^32.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_reg <= '0;
        end else if (inc[gi]) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end

      assign cnt_all[gi] = cnt_reg;
    end
  endgenerate

  assign fetch_cnt  = cnt_all[0];
  assign bubble_cnt = cnt_all[1];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: word PC, single-outstanding imem port, one-entry
// fetch buffer and the IF/ID register. Jumps resolved in ID use delay-slot
// semantics. Optional IF_PERF_CNT_EN adds handoff/bubble counters.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pc_write,
  input  logic        if_flush,
  input  logic [29:0] flush_pc,
  input  logic [29:0] jpc,
  input  logic        jpc_avail,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [29:0] id_pcp1,
  output logic [31:0] id_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

  fetch_state_t state_reg, state_next;
  logic [29:0]  pc_reg;
  logic         redir_v_reg;
  logic [29:0]  redir_pc_reg;
  logic [29:0]  fbuf_pc_reg;
  logic [31:0]  fbuf_instr_reg;
  logic         id_valid_reg;
  logic [29:0]  id_pcp1_reg;
  logic [31:0]  id_instr_reg;

  logic         avail;
  logic         handoff;
  logic         bubble;
  logic         capture;
  logic         fbuf_load;
  logic [29:0]  fetch_pc;
  logic [31:0]  fetch_instr;
  logic [29:0]  target;

  // An instruction is ready either from the buffer or straight off the memory bus.
  assign avail       = (state_reg == S_FULL) | ((state_reg == S_WAIT) & imem_ack);
  assign fetch_pc    = (state_reg == S_FULL) ? fbuf_pc_reg : pc_reg;
  assign fetch_instr = (state_reg == S_FULL) ? fbuf_instr_reg : imem_rdata;
  assign handoff     = pc_write & avail & ~if_flush;
  assign bubble      = if_flush | (pc_write & ~avail);
  // A taken jump seen before its delay slot arrives is remembered for that slot.
  assign capture     = pc_write & jpc_avail & ~handoff & ~if_flush;
  assign fbuf_load   = (state_reg == S_WAIT) & imem_ack & ~pc_write & ~if_flush;
  assign target      = jpc_avail   ? jpc :
                       redir_v_reg ? redir_pc_reg : word_inc(pc_reg);

  assign imem_req  = (state_reg == S_REQ) & ~if_flush;
  assign imem_addr = pc_reg;
  assign id_valid  = id_valid_reg;
  assign id_pcp1   = id_pcp1_reg;
  assign id_instr  = id_instr_reg;

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a flush with a request still outstanding must swallow its ack.
  always_comb begin
    state_next = state_reg;
    if (if_flush) begin
      if (((state_reg == S_WAIT) || (state_reg == S_DROP)) && !imem_ack) begin
        state_next = S_DROP;
      end else begin
        state_next = S_REQ;
      end
    end else begin
      case (state_reg)
        S_REQ:   state_next = S_WAIT;
        S_WAIT:  if (imem_ack) state_next = pc_write ? S_REQ : S_FULL;
        S_FULL:  if (pc_write) state_next = S_REQ;
        S_DROP:  if (imem_ack) state_next = S_REQ;
        default: state_next = S_REQ;
      endcase
    end
  end

  // PC and pending-redirect registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_reg       <= RESET_WORD;
      redir_v_reg  <= 1'b0;
      redir_pc_reg <= '0;
    end else if (if_flush) begin
      pc_reg      <= flush_pc;
      redir_v_reg <= 1'b0;
    end else if (handoff) begin
      pc_reg      <= target;
      redir_v_reg <= 1'b0;
    end else if (capture) begin
      redir_pc_reg <= jpc;
      redir_v_reg  <= 1'b1;
    end
  end

  // One-entry fetch buffer, filled when data returns during a stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fbuf_pc_reg    <= '0;
      fbuf_instr_reg <= NOP_INSTR;
    end else if (fbuf_load) begin
      fbuf_pc_reg    <= pc_reg;
      fbuf_instr_reg <= imem_rdata;
    end
  end

  // IF/ID pipeline register: load on handoff, bubble otherwise, hold on stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_valid_reg <= 1'b0;
      id_pcp1_reg  <= '0;
      id_instr_reg <= NOP_INSTR;
    end else if (handoff) begin
      id_valid_reg <= 1'b1;
      id_pcp1_reg  <= word_inc(fetch_pc);
      id_instr_reg <= fetch_instr;
    end else if (bubble) begin
      id_valid_reg <= 1'b0;
      id_instr_reg <= NOP_INSTR;
    end
  end

  // Exactly one request in flight: a response is only legal while one is outstanding.
  assert property (@(posedge clk) disable iff (!rstn)
    imem_ack |-> ((state_reg == S_WAIT) || (state_reg == S_DROP)));

`ifdef IF_PERF_CNT_EN
  if_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .inc_fetch  (handoff),
    .inc_bubble (bubble),
    .fetch_cnt  (perf_fetch_cnt),
    .bubble_cnt (perf_bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: variable-latency memory model, scoreboard of
// expected IF/ID handoffs, and directed stream/stall/jump/flush/wrap sequences.
// Counter checks are compiled in when IF_PERF_CNT_EN is defined.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pc_write;
  logic        if_flush;
  logic [29:0] flush_pc;
  logic [29:0] jpc;
  logic        jpc_avail;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [29:0] id_pcp1;
  logic [31:0] id_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int lat      = 1;

  logic [29:0] exp_pc_q[$];
  logic [31:0] exp_in_q[$];

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pc_write   (pc_write),
    .if_flush   (if_flush),
    .flush_pc   (flush_pc),
    .jpc        (jpc),
    .jpc_avail  (jpc_avail),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_pcp1    (id_pcp1),
    .id_instr   (id_instr)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [29:0] a);
    return {a, 2'b10} ^ 32'hC3C3_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [29:0] pcp1, input logic [31:0] instr);
    exp_pc_q.push_back(pcp1);
    exp_in_q.push_back(instr);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: accepts a request at the edge, acks lat cycles later, drops on reset.
  initial begin : mem_model
    logic        req_s;
    logic        rst_s;
    logic [29:0] addr_s;
    logic [29:0] paddr;
    logic        pend;
    int          cnt;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    pend       = 1'b0;
    paddr      = '0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      req_s  = imem_req;
      addr_s = imem_addr;
      rst_s  = rstn;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      if (!rstn || !rst_s) begin
        pend = 1'b0;
      end else begin
        if (req_s) begin
          pend  = 1'b1;
          paddr = addr_s;
          cnt   = lat;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = instr_of(paddr);
            pend       = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: after every edge where IF/ID could load, compare against the scoreboard.
  initial begin : monitor
    logic        load_s;
    logic        rst_s;
    logic [29:0] e_pc;
    logic [31:0] e_in;
    load_s = 1'b0;
    rst_s  = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && rst_s && load_s) begin
        if (id_valid) begin
          if (exp_pc_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_handoff: got pcp1=%h instr=%h expected none", id_pcp1, id_instr);
          end else begin
            e_pc = exp_pc_q.pop_front();
            e_in = exp_in_q.pop_front();
            chk("handoff_pcp1", 32'(id_pcp1), 32'(e_pc));
            chk("handoff_instr", id_instr, e_in);
            $display("handoff pcp1=%h instr=%h", id_pcp1, id_instr);
          end
        end else begin
          chk("bubble_instr", id_instr, 32'h0);
        end
      end
      load_s = pc_write | if_flush;
      rst_s  = rstn;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rstn = 1'b0; pc_write = 1'b1; if_flush = 1'b0;
    flush_pc = '0; jpc = '0; jpc_avail = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pcp1", 32'(id_pcp1), 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);

    // c0: first request right out of reset
    step(); rstn = 1'b1;
    for (int i = 0; i < 3; i++) push(30'h0C01 + 30'(i), instr_of(30'h0C00 + 30'(i)));
    @(negedge clk);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'h0C00);

    // Stream c0..c5: three handoffs with bubbles between
    repeat (6) step();
    // c6: stall; data arrives in c7 and is buffered
    pc_write = 1'b0;
    push(30'h0C04, instr_of(30'h0C03));
    step(); step();                              // c8
    @(negedge clk);
    chk("stall_req_idle", 32'(imem_req), 32'd0);
    chk("stall_id_valid_held", 32'(id_valid), 32'd1);
    chk("stall_id_pcp1_held", 32'(id_pcp1), 32'h0C03);
    step(); step();                              // c10
    pc_write = 1'b1;
    step();                                      // c11
    @(negedge clk);
    chk("after_stall_req", 32'(imem_req), 32'd1);
    chk("after_stall_addr", 32'(imem_addr), 32'h0C04);

    // Jump captured while the delay slot (0C04) is still outstanding
    lat = 2;
    push(30'h0C05, instr_of(30'h0C04));
    step();                                      // c12
    jpc_avail = 1'b1; jpc = 30'h0D00;
    step();                                      // c13
    jpc_avail = 1'b0;
    step();                                      // c14
    @(negedge clk);
    chk("jump_addr", 32'(imem_addr), 32'h0D00);
    chk("jump_req", 32'(imem_req), 32'd1);

    // Flush while 0D00 is outstanding; its late ack must be dropped
    lat = 3;
    step();                                      // c15
    if_flush = 1'b1; flush_pc = 30'h1060;
    @(negedge clk);
    chk("flush_req_masked", 32'(imem_req), 32'd0);
    step();                                      // c16
    if_flush = 1'b0; lat = 1;
    @(negedge clk);
    chk("drop_req_idle", 32'(imem_req), 32'd0);
    chk("drop_id_valid_c16", 32'(id_valid), 32'd0);
    step();                                      // c17 (stale ack)
    @(negedge clk);
    chk("drop_id_valid_c17", 32'(id_valid), 32'd0);
    step();                                      // c18
    @(negedge clk);
    chk("flush_addr", 32'(imem_addr), 32'h1060);
    chk("flush_req", 32'(imem_req), 32'd1);
    chk("drop_id_valid_c18", 32'(id_valid), 32'd0);
    push(30'h1061, instr_of(30'h1060));

    // Wrap: restart at the top word address
    step();                                      // c19 handoff 1061
    step();                                      // c20
    if_flush = 1'b1; flush_pc = 30'h3FFF_FFFF;
    push(30'h0, instr_of(30'h3FFF_FFFF));
    step();                                      // c21
    if_flush = 1'b0;
    @(negedge clk);
    chk("wrap_start_addr", 32'(imem_addr), 32'h3FFF_FFFF);
    step(); step();                              // c23
    @(negedge clk);
    chk("wrap_next_addr", 32'(imem_addr), 32'h0);
    #1 rstn = 1'b0;

    // Second reset, then 10 handoffs and exactly 3 bubbles
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 0; i < 10; i++) push(30'h0C01 + 30'(i), instr_of(30'h0C00 + 30'(i)));
    for (int k = 0; k < 20; k++) begin
      pc_write = ((k % 2) == 1) || (k < 5);
      step();
    end
    @(negedge clk);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
    chk("perf_bubble_cnt", perf_bubble_cnt, 32'd3);
`endif
    step();
    pc_write = 1'b0;
    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_pc_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Directly upstream of ID, and the sole producer of the ID_DATA pair (PC+1, instr).
- Owns the word PC and a one-outstanding request/ack port to instruction memory. Memory latency is variable.
- Owns a one-entry fetch buffer and the IF/ID pipeline register.
- Consumes PCWrite (stall), IF_FLUSH with its restart address, and the ID-resolved jump target JPC/jpcAvail. Jumps use delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_3000, byte reset address. Only bits [31:2] are used.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- pc_write  in  1  PCWrite; 0 = stall IF and hold IF/ID
- if_flush  in  1  IF_FLUSH; discard all IF state and restart at flush_pc
- flush_pc  in  30  restart word address (EPC or handler), [31:2]
- jpc  in  30  jump/branch target from ID, [31:2]
- jpc_avail  in  1  jpc valid this cycle (instruction in ID is taken)
- imem_req  out  1  fetch request; memory accepts in the same cycle
- imem_addr  out  30  fetch word address
- imem_ack  in  1  response valid; arrives ≥1 cycle after req
- imem_rdata  in  32  instruction word, valid with imem_ack
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- id_pcp1  out  30  ID_PCP1: fetched word PC + 1
- id_instr  out  32  ID_instr; 0 (nop) when id_valid=0

Behaviour:
- Reset state:
  - pc = RESET_PC[31:2], state = S_REQ.
  - id_valid = 0, id_pcp1 = 0, id_instr = 0.
  - redir_v = 0, fbuf cleared.
- imem_req = (state == S_REQ) & ~if_flush. imem_addr = pc. Both are combinational from registered state.
- States and transitions:
  - S_REQ: issue request → S_WAIT.
  - S_WAIT: outstanding request.
    - imem_ack & handoff → S_REQ.
    - imem_ack & ~pc_write → latch fbuf (fpc = pc, instr) → S_FULL.
  - S_FULL: buffered instruction, request line idle. pc_write → handoff → S_REQ.
  - S_DROP: stale request outstanding. imem_ack → discard → S_REQ.
- avail = (S_FULL) | (S_WAIT & imem_ack). In the S_WAIT case the data bypasses fbuf straight from imem_rdata.
- handoff = pc_write & avail & ~if_flush. On handoff:
  - id_valid ← 1, id_pcp1 ← fpc+1, id_instr ← data.
  - pc ← target.
  - redir_v ← 0.
- target = jpc_avail ? jpc : (redir_v ? redir_pc : pc+1). Addition is 30-bit and wraps.
- Delay slot:
  - A jump in ID with jpc_avail, while the slot is not yet available: if pc_write=1 and no handoff, capture redir_pc ← jpc, redir_v ← 1.
  - The next handoff (the delay slot) then steers pc to the target.
- pc_write=1 & ~avail (and no flush): IF/ID ← bubble (id_valid 0, id_instr 0). pc unchanged.
- pc_write=0: IF/ID and pc hold. A redirect is not captured.
- if_flush has highest priority over stall, handoff and redirect:
  - IF/ID ← bubble, pc ← flush_pc, redir_v ← 0, fbuf invalid.
  - If state is S_WAIT and no ack this cycle → S_DROP. Otherwise → S_REQ.
  - An ack in the flush cycle is discarded.
- Flush while in S_DROP: stay in S_DROP; pc updates to the new flush_pc.
- Exactly one request is in flight. imem_ack in S_REQ or S_FULL is illegal; it must fire an assertion.
- Throughput: one instruction per 2 cycles with a 1-cycle memory.
- Reset mid-request: state returns asynchronously. Memory must drop any pending ack under the same reset.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (handoffs) and perf_bubble_cnt[31:0] (bubbles inserted, including flush bubbles).
  - Both counters wrap, reset to 0, and count only cycles with pc_write=1 or if_flush=1.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- The ID_DATA struct and the control structs stay in the pipeline-interfaces header.
- Shared package cpu_pkg holds:
  - the enum fetch_state_t {S_REQ, S_WAIT, S_FULL, S_DROP};
  - RESET_PC_DEFAULT;
  - the NOP_INSTR = 32'h0 constant.
- One sub-module is natural: if_perf_cnt (the two counters), instantiated only under IF_PERF_CNT_EN. The fetch FSM stays flat.

Test Plan:
- Reset: release rstn → first cycle imem_req=1, imem_addr=30'h0C00. id_valid=0, id_instr=0 until the first handoff.
- Stream: ack 1 cycle after each req, pc_write=1 → id_pcp1 = 0C01, 0C02, 0C03 on alternate cycles, with bubbles between.
- Stall: ack while pc_write=0 → S_FULL, imem_req=0, IF/ID held. pc_write=1 two cycles later → buffered instr handed off, next imem_addr = fpc+1.
- Jump: jpc_avail=1, jpc=30'h0D00 while the delay slot is in S_WAIT → slot handed off with id_pcp1 = slot+1. Next imem_addr=0D00.
- Flush mid-flight: if_flush=1, flush_pc=30'h1060 in S_WAIT, ack 3 cycles later → stale data never reaches ID. Next imem_addr=1060, id_valid=0 throughout.
- Wrap/perf: pc=30'h3FFF_FFFF handoff → id_pcp1=0, next addr 0. With IF_PERF_CNT_EN, 10 handoffs + 3 bubbles → counters read 10 and 3.
